// File: rtl/trigger_conditioner.sv
// Trigger conditioner: synchronises a raw trigger, detects the selected edge/level,
// and emits one delayed, width-controlled capture pulse with holdoff and event counters.
module trigger_conditioner #(
  parameter int DELAY_W   = 32,
  parameter int WIDTH_W   = 16,
  parameter int HOLDOFF_W = 32,
  parameter int CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 reset_i,
  input  logic                 trig_i,
  input  logic [1:0]           edge_sel_i,
  input  logic                 arm_i,
  input  logic                 disarm_i,
  input  logic                 oneshot_i,
  input  logic [DELAY_W-1:0]   delay_i,
  input  logic [WIDTH_W-1:0]   pulse_width_i,
  input  logic [HOLDOFF_W-1:0] holdoff_i,
  input  logic                 clr_cnt_i,
  output logic                 armed_o,
  output logic                 busy_o,
  output logic                 trig_o,
  output logic [CNT_W-1:0]     trig_count_o,
  output logic [CNT_W-1:0]     missed_count_o
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ARMED   = 3'd1,
    DELAY   = 3'd2,
    PULSE   = 3'd3,
    HOLDOFF = 3'd4
  } state_t;

  state_t state, next_state;

  logic sync1, sync2, hist;
  logic evt, evt_q;
  logic accept, miss, busy_state;

  logic [DELAY_W-1:0]   dly_cnt;
  logic [WIDTH_W-1:0]   wid_cnt;
  logic [HOLDOFF_W-1:0] hold_cnt;
  logic                 hold_nz;
  logic                 oneshot_sh;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; blocking here would collapse the synchroniser chain.
  always_ff @(posedge clk or negedge reset_i) begin
    if (!reset_i) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      hist  <= 1'b0;
      evt_q <= 1'b0;
    end else begin
      sync1 <= trig_i;
      sync2 <= sync1;
      hist  <= sync2;
      evt_q <= evt;
    end
  end

  // NOTE: every signal written in always_comb gets a default first; a missing
  // branch would otherwise infer a latch.
  always_comb begin
    evt = 1'b0;
    case (edge_sel_i)
      2'b00:   evt = sync2 & ~hist;
      2'b01:   evt = ~sync2 & hist;
      2'b10:   evt = sync2 ^ hist;
      default: evt = sync2;
    endcase
  end

  assign busy_state = (state == DELAY) || (state == PULSE) || (state == HOLDOFF);
  assign miss       = evt_q && busy_state;

  always_comb begin
    next_state = state;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        if (arm_i) next_state = ARMED;
      end
      ARMED: begin
        if (evt_q) begin
          accept     = 1'b1;
          next_state = (delay_i != '0) ? DELAY : PULSE;
        end
      end
      DELAY: begin
        if (dly_cnt == '0) next_state = PULSE;
      end
      PULSE: begin
        if (wid_cnt == '0) begin
          if (hold_nz)         next_state = HOLDOFF;
          else if (oneshot_sh) next_state = IDLE;
          else                 next_state = ARMED;
        end
      end
      HOLDOFF: begin
        if (hold_cnt == '0) next_state = oneshot_sh ? IDLE : ARMED;
      end
      default: next_state = IDLE;
    endcase
    // Disarm overrides everything, including a simultaneous arm or event.
    if (disarm_i) begin
      next_state = IDLE;
      accept     = 1'b0;
    end
  end

  // NOTE: shadow registers are ordinary flops, so they are reset along with the
  // rest of the state; nothing here is a memory that could skip reset.
  always_ff @(posedge clk or negedge reset_i) begin
    if (!reset_i) begin
      state      <= IDLE;
      dly_cnt    <= '0;
      wid_cnt    <= '0;
      hold_cnt   <= '0;
      hold_nz    <= 1'b0;
      oneshot_sh <= 1'b0;
    end else begin
      state <= next_state;
      if (accept) begin
        // Counters are loaded with N-1 so each phase lasts exactly N cycles.
        dly_cnt    <= delay_i - DELAY_W'(1);
        wid_cnt    <= (pulse_width_i == '0) ? '0 : pulse_width_i - WIDTH_W'(1);
        hold_cnt   <= holdoff_i - HOLDOFF_W'(1);
        hold_nz    <= (holdoff_i != '0);
        oneshot_sh <= oneshot_i;
      end else begin
        case (state)
          DELAY:   if (dly_cnt  != '0) dly_cnt  <= dly_cnt  - DELAY_W'(1);
          PULSE:   if (wid_cnt  != '0) wid_cnt  <= wid_cnt  - WIDTH_W'(1);
          HOLDOFF: if (hold_cnt != '0) hold_cnt <= hold_cnt - HOLDOFF_W'(1);
          default: ;
        endcase
      end
    end
  end

  // Outputs are registered from the state; disarm forces them low on the same edge.
  always_ff @(posedge clk or negedge reset_i) begin
    if (!reset_i) begin
      trig_o  <= 1'b0;
      armed_o <= 1'b0;
      busy_o  <= 1'b0;
    end else begin
      trig_o  <= (state == PULSE) && !disarm_i;
      armed_o <= (state == ARMED) && !disarm_i;
      busy_o  <= busy_state && !disarm_i;
    end
  end

  always_ff @(posedge clk or negedge reset_i) begin
    if (!reset_i) begin
      trig_count_o   <= '0;
      missed_count_o <= '0;
    end else if (clr_cnt_i) begin
      trig_count_o   <= '0;
      missed_count_o <= '0;
    end else begin
      if (accept && (trig_count_o != '1))  trig_count_o   <= trig_count_o + CNT_W'(1);
      if (miss && (missed_count_o != '1))  missed_count_o <= missed_count_o + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_trigger_conditioner.sv
// Bench for trigger_conditioner: a negedge monitor checks every trig_o pulse
// (start cycle and width) against a queue of expected pulses; tasks check status and counters.
module tb_trigger_conditioner;

  logic        clk = 1'b0;
  logic        reset_i;
  logic        trig_i;
  logic [1:0]  edge_sel_i;
  logic        arm_i, disarm_i, oneshot_i, clr_cnt_i;
  logic [31:0] delay_i;
  logic [15:0] pulse_width_i;
  logic [31:0] holdoff_i;
  logic        armed_o, busy_o, trig_o;
  logic [15:0] trig_count_o, missed_count_o;
  logic        s_armed, s_busy, s_trig;
  logic [3:0]  s_trig_count, s_missed_count;

  trigger_conditioner dut (
    .clk(clk), .reset_i(reset_i), .trig_i(trig_i), .edge_sel_i(edge_sel_i),
    .arm_i(arm_i), .disarm_i(disarm_i), .oneshot_i(oneshot_i), .delay_i(delay_i),
    .pulse_width_i(pulse_width_i), .holdoff_i(holdoff_i), .clr_cnt_i(clr_cnt_i),
    .armed_o(armed_o), .busy_o(busy_o), .trig_o(trig_o),
    .trig_count_o(trig_count_o), .missed_count_o(missed_count_o)
  );

  trigger_conditioner #(.CNT_W(4)) dut_s (
    .clk(clk), .reset_i(reset_i), .trig_i(trig_i), .edge_sel_i(edge_sel_i),
    .arm_i(arm_i), .disarm_i(disarm_i), .oneshot_i(oneshot_i), .delay_i(delay_i),
    .pulse_width_i(pulse_width_i), .holdoff_i(holdoff_i), .clr_cnt_i(clr_cnt_i),
    .armed_o(s_armed), .busy_o(s_busy), .trig_o(s_trig),
    .trig_count_o(s_trig_count), .missed_count_o(s_missed_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int start;
    int width;
  } pulse_t;

  pulse_t exp_q[$];
  int total = 0;
  int bad = 0;
  int exp_trig = 0;
  int exp_miss = 0;

  logic prev_trig = 1'b0;
  int   rise_cyc  = 0;

  always @(negedge clk) begin
    pulse_t p;
    if (trig_o && !prev_trig) rise_cyc = cyc;
    if (!trig_o && prev_trig) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL pulse_unexpected: got start=%0d width=%0d, expected no pulse", rise_cyc, cyc - rise_cyc);
      end else begin
        p = exp_q.pop_front();
        if (rise_cyc !== p.start || (cyc - rise_cyc) !== p.width) begin
          bad++;
          $display("FAIL pulse_shape: got start=%0d width=%0d, expected start=%0d width=%0d",
                   rise_cyc, cyc - rise_cyc, p.start, p.width);
        end
      end
    end
    prev_trig = trig_o;
  end

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic pulse_arm();
    arm_i = 1'b1; @(negedge clk); arm_i = 1'b0;
  endtask

  task automatic pulse_disarm();
    disarm_i = 1'b1; @(negedge clk); disarm_i = 1'b0;
  endtask

  task automatic pulse_clr();
    clr_cnt_i = 1'b1; @(negedge clk); clr_cnt_i = 1'b0;
  endtask

  task automatic cfg(input logic [1:0] sel, input int d, input int w, input int h, input logic os);
    edge_sel_i    = sel;
    delay_i       = d;
    pulse_width_i = 16'(w);
    holdoff_i     = h;
    oneshot_i     = os;
  endtask

  task automatic test_reset();
    total++;
    if ({trig_o, armed_o, busy_o, trig_count_o, missed_count_o} !== 35'd0) begin
      bad++;
      $display("FAIL reset_outputs: got trig=%b armed=%b busy=%b cnt=%0d miss=%0d, expected all 0",
               trig_o, armed_o, busy_o, trig_count_o, missed_count_o);
    end
    total++;
    if ({s_trig, s_armed, s_busy, s_trig_count, s_missed_count} !== 11'd0) begin
      bad++;
      $display("FAIL reset_outputs_small: got cnt=%0d miss=%0d, expected 0", s_trig_count, s_missed_count);
    end
  endtask

  task automatic test_rising_basic();
    int n;
    cfg(2'b00, 0, 1, 0, 1'b1);
    pulse_arm();
    @(negedge clk);
    total++;
    if (armed_o !== 1'b1) begin bad++; $display("FAIL basic_armed: got %b expected 1", armed_o); end
    n = cyc + 1;
    trig_i = 1'b1;
    exp_q.push_back('{start: n + 4, width: 1});
    exp_trig++;
    wait_until(n + 6);
    trig_i = 1'b0;
    total++;
    if (armed_o !== 1'b0 || busy_o !== 1'b0) begin
      bad++; $display("FAIL basic_after: got armed=%b busy=%b expected 0 0", armed_o, busy_o);
    end
    total++;
    if (trig_count_o !== 16'(exp_trig)) begin
      bad++; $display("FAIL basic_count: got %0d expected %0d", trig_count_o, exp_trig);
    end
  endtask

  task automatic test_delay_holdoff();
    int n;
    cfg(2'b00, 10, 5, 20, 1'b0);
    pulse_arm();
    @(negedge clk);
    n = cyc + 1;
    trig_i = 1'b1;
    exp_q.push_back('{start: n + 14, width: 5});
    exp_trig++;
    exp_miss++;
    wait_until(n + 4);
    trig_i = 1'b0;
    // In-flight trigger must keep its latched width and holdoff.
    pulse_width_i = 16'd2;
    holdoff_i     = 32'd3;
    wait_until(n + 8);
    trig_i = 1'b1;
    wait_until(n + 12);
    trig_i = 1'b0;
    wait_until(n + 20);
    total++;
    if (busy_o !== 1'b1 || armed_o !== 1'b0) begin
      bad++; $display("FAIL holdoff_busy: got busy=%b armed=%b expected 1 0", busy_o, armed_o);
    end
    wait_until(n + 38);
    total++;
    if (armed_o !== 1'b0) begin bad++; $display("FAIL holdoff_early: got armed=%b expected 0", armed_o); end
    wait_until(n + 39);
    total++;
    if (armed_o !== 1'b1) begin bad++; $display("FAIL holdoff_rearm: got armed=%b expected 1", armed_o); end
    total++;
    if (missed_count_o !== 16'(exp_miss) || trig_count_o !== 16'(exp_trig)) begin
      bad++; $display("FAIL delay_counts: got cnt=%0d miss=%0d expected %0d %0d",
                      trig_count_o, missed_count_o, exp_trig, exp_miss);
    end
    pulse_disarm();
  endtask

  task automatic test_falling_both();
    int n;
    cfg(2'b01, 0, 1, 0, 1'b0);
    pulse_arm();
    @(negedge clk);
    n = cyc + 1;
    trig_i = 1'b1;
    exp_q.push_back('{start: n + 54, width: 1});
    exp_trig++;
    wait_until(n + 49);
    trig_i = 1'b0;
    wait_until(n + 60);
    total++;
    if (trig_count_o !== 16'(exp_trig) || armed_o !== 1'b1) begin
      bad++; $display("FAIL falling_count: got cnt=%0d armed=%b expected %0d 1", trig_count_o, armed_o, exp_trig);
    end
    pulse_disarm();

    cfg(2'b10, 0, 1, 0, 1'b0);
    pulse_arm();
    @(negedge clk);
    n = cyc + 1;
    trig_i = 1'b1;
    exp_q.push_back('{start: n + 4, width: 1});
    exp_q.push_back('{start: n + 54, width: 1});
    exp_trig += 2;
    wait_until(n + 49);
    trig_i = 1'b0;
    wait_until(n + 60);
    total++;
    if (trig_count_o !== 16'(exp_trig) || missed_count_o !== 16'(exp_miss)) begin
      bad++; $display("FAIL both_count: got cnt=%0d miss=%0d expected %0d %0d",
                      trig_count_o, missed_count_o, exp_trig, exp_miss);
    end
    pulse_disarm();
  endtask

  task automatic test_disarm();
    int n;
    // Abort during DELAY.
    cfg(2'b00, 20, 10, 0, 1'b0);
    pulse_arm();
    @(negedge clk);
    n = cyc + 1;
    trig_i = 1'b1;
    exp_trig++;
    wait_until(n + 6);
    total++;
    if (busy_o !== 1'b1) begin bad++; $display("FAIL disarm_delay_busy: got %b expected 1", busy_o); end
    pulse_disarm();
    total++;
    if (trig_o !== 1'b0 || busy_o !== 1'b0 || armed_o !== 1'b0) begin
      bad++; $display("FAIL disarm_delay: got trig=%b busy=%b armed=%b expected 0 0 0", trig_o, busy_o, armed_o);
    end
    trig_i = 1'b0;
    repeat (5) @(negedge clk);
    trig_i = 1'b1;
    repeat (30) @(negedge clk);
    trig_i = 1'b0;
    total++;
    if (trig_count_o !== 16'(exp_trig) || missed_count_o !== 16'(exp_miss)) begin
      bad++; $display("FAIL disarm_delay_counts: got cnt=%0d miss=%0d expected %0d %0d",
                      trig_count_o, missed_count_o, exp_trig, exp_miss);
    end

    // Abort during PULSE: trig_o truncated after two cycles.
    cfg(2'b00, 0, 10, 0, 1'b0);
    pulse_arm();
    @(negedge clk);
    n = cyc + 1;
    trig_i = 1'b1;
    exp_q.push_back('{start: n + 4, width: 2});
    exp_trig++;
    wait_until(n + 5);
    total++;
    if (trig_o !== 1'b1) begin bad++; $display("FAIL disarm_pulse_high: got %b expected 1", trig_o); end
    pulse_disarm();
    total++;
    if (trig_o !== 1'b0 || busy_o !== 1'b0 || armed_o !== 1'b0) begin
      bad++; $display("FAIL disarm_pulse: got trig=%b busy=%b armed=%b expected 0 0 0", trig_o, busy_o, armed_o);
    end
    trig_i = 1'b0;
    repeat (5) @(negedge clk);
    trig_i = 1'b1;
    repeat (30) @(negedge clk);
    trig_i = 1'b0;
    total++;
    if (trig_count_o !== 16'(exp_trig)) begin
      bad++; $display("FAIL disarm_pulse_count: got %0d expected %0d", trig_count_o, exp_trig);
    end
  endtask

  task automatic test_saturation();
    int n;
    pulse_clr();
    exp_trig = 0;
    exp_miss = 0;
    cfg(2'b00, 0, 1, 0, 1'b0);
    pulse_arm();
    @(negedge clk);
    for (int i = 0; i < 20; i++) begin
      n = cyc + 1;
      trig_i = 1'b1;
      exp_q.push_back('{start: n + 4, width: 1});
      exp_trig++;
      repeat (4) @(negedge clk);
      trig_i = 1'b0;
      repeat (4) @(negedge clk);
    end
    total++;
    if (s_trig_count !== 4'd15 || s_missed_count !== 4'd0) begin
      bad++; $display("FAIL sat_small: got cnt=%0d miss=%0d expected 15 0", s_trig_count, s_missed_count);
    end
    total++;
    if (trig_count_o !== 16'(exp_trig)) begin
      bad++; $display("FAIL sat_wide: got %0d expected %0d", trig_count_o, exp_trig);
    end
    // Clear lands on the same edge as the accepted event.
    n = cyc + 1;
    trig_i = 1'b1;
    exp_q.push_back('{start: n + 4, width: 1});
    wait_until(n + 2);
    pulse_clr();
    total++;
    if (s_trig_count !== 4'd0 || trig_count_o !== 16'd0) begin
      bad++; $display("FAIL clr_priority: got small=%0d wide=%0d expected 0 0", s_trig_count, trig_count_o);
    end
    exp_trig = 0;
    repeat (4) @(negedge clk);
    trig_i = 1'b0;
    pulse_disarm();
  endtask

  task automatic test_async_reset();
    int n;
    cfg(2'b00, 0, 10, 0, 1'b0);
    pulse_arm();
    @(negedge clk);
    n = cyc + 1;
    trig_i = 1'b1;
    exp_q.push_back('{start: n + 4, width: 1});
    wait_until(n + 4);
    total++;
    if (trig_o !== 1'b1) begin bad++; $display("FAIL rst_pre_high: got %b expected 1", trig_o); end
    #2 reset_i = 1'b0;
    #1;
    total++;
    if (trig_o !== 1'b0 || armed_o !== 1'b0 || busy_o !== 1'b0) begin
      bad++; $display("FAIL rst_async_out: got trig=%b armed=%b busy=%b expected 0 0 0", trig_o, armed_o, busy_o);
    end
    total++;
    if (trig_count_o !== 16'd0 || missed_count_o !== 16'd0 || s_trig_count !== 4'd0) begin
      bad++; $display("FAIL rst_async_cnt: got cnt=%0d miss=%0d small=%0d expected 0", trig_count_o, missed_count_o, s_trig_count);
    end
    @(negedge clk);
    reset_i = 1'b1;
    exp_trig = 0;
    exp_miss = 0;
    repeat (10) @(negedge clk);
    total++;
    if (armed_o !== 1'b0 || busy_o !== 1'b0 || trig_count_o !== 16'd0) begin
      bad++; $display("FAIL rst_idle: got armed=%b busy=%b cnt=%0d expected 0 0 0", armed_o, busy_o, trig_count_o);
    end
    trig_i = 1'b0;
    repeat (4) @(negedge clk);
    pulse_arm();
    @(negedge clk);
    n = cyc + 1;
    trig_i = 1'b1;
    exp_q.push_back('{start: n + 4, width: 10});
    exp_trig++;
    wait_until(n + 20);
    trig_i = 1'b0;
    total++;
    if (trig_count_o !== 16'(exp_trig)) begin
      bad++; $display("FAIL rst_rearm_count: got %0d expected %0d", trig_count_o, exp_trig);
    end
  endtask

  initial begin
    reset_i = 1'b0;
    trig_i = 1'b0;
    arm_i = 1'b0;
    disarm_i = 1'b0;
    clr_cnt_i = 1'b0;
    cfg(2'b00, 0, 1, 0, 1'b0);
    repeat (3) @(negedge clk);
    test_reset();
    reset_i = 1'b1;
    repeat (2) @(negedge clk);
    test_rising_basic();
    test_delay_holdoff();
    test_falling_both();
    test_disarm();
    test_saturation();
    test_async_reset();
    repeat (5) @(negedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++; $display("FAIL pulses_outstanding: got %0d left expected 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
